riscv_dmem_ctrl: RTL and testbench

Parametrised data-memory controller with integrated storage for the RISC-V core's MEM stage. It accepts one load/store request at a time over a valid/ready handshake and decodes funct3 into byte-lane enables. It checks alignment, performs the sub-word write or read, sign- or zero-extends load data, and returns a response after a configurable wait-state latency under response backpressure. It replaces the fixed-width, zero-latency data memory for the asynchronous-pipeline variants, which need wait states and stall handshakes.

---
 rtl/riscv_dmem_ctrl.sv | 161 ++++++++++++++++
 tb/tb_riscv_dmem_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_dmem_ctrl.sv
// riscv_dmem_ctrl: data-memory controller with integrated storage for the
// RISC-V MEM stage. Accepts one load/store at a time over valid/ready, checks
// size legality and alignment, writes sub-word stores into byte lanes, and
// returns sign/zero-extended load data after RD_LAT wait states plus a
// registered read cycle, holding the response under backpressure.
module riscv_dmem_ctrl #(
  parameter int XLEN     = 32,  // 32 or 64
  parameter int ADDR_BIT = 12,  // byte-address width
  parameter int RD_LAT   = 1    // wait states, 0..7
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic                i_req_we,
  input  logic [2:0]          i_req_funct3,
  input  logic [ADDR_BIT-1:0] i_req_addr,
  input  logic [XLEN-1:0]     i_req_wdata,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [XLEN-1:0]     o_rsp_rdata,
  output logic                o_rsp_err
);

  localparam int         NB    = XLEN / 8;
  localparam int         OFS   = $clog2(NB);
  localparam int         IDX_W = ADDR_BIT - OFS;
  localparam int         WORDS = 2 ** IDX_W;
  localparam bit         IS32  = (XLEN == 32);
  localparam logic [2:0] LAT   = 3'(RD_LAT);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          state;
  logic [2:0]      wait_cnt;
  logic [XLEN-1:0] mem [WORDS];

  logic                lat_we;
  logic [2:0]          lat_funct3;
  logic [ADDR_BIT-1:0] lat_addr;
  logic                lat_err;

  logic [1:0]       req_size;
  logic [OFS-1:0]   req_off;
  logic [OFS-1:0]   req_mask;
  logic [IDX_W-1:0] req_idx;
  logic             req_illegal;
  logic             req_misal;
  logic             req_err;
  logic [NB-1:0]    req_be;
  logic [XLEN-1:0]  req_wsh;
  logic             accept;

  logic [IDX_W-1:0] lat_idx;
  logic [OFS-1:0]   lat_off;
  logic [1:0]       lat_size;
  logic [XLEN-1:0]  rd_shift;
  logic [XLEN-1:0]  load_data;
  logic             ext_bit;
  int               nbits;

  // Decode the presented request: size legality, alignment, lane enables and lane-aligned store data
  always_comb begin
    req_size    = i_req_funct3[1:0];
    req_off     = i_req_addr[OFS-1:0];
    req_idx     = i_req_addr[ADDR_BIT-1:OFS];
    req_mask    = OFS'((4'd1 << req_size) - 4'd1);
    req_illegal = (IS32 && (req_size == 2'd3)) ||
                  (i_req_funct3 == 3'b111) ||
                  (IS32 && (i_req_funct3 == 3'b110)) ||
                  (i_req_we && i_req_funct3[2]);
    req_misal   = (req_off & req_mask) != '0;
    req_err     = req_illegal || req_misal;
    req_wsh     = i_req_wdata << {req_off, 3'b000};
    for (int b = 0; b < NB; b++) begin
      req_be[b] = (b >= int'(req_off)) && (b < int'(req_off) + (1 << req_size));
    end
    accept      = (state == S_IDLE) && i_req_valid;
  end

  // Byte-lane store at the acceptance edge; an edge with reset held high never writes
  always_ff @(posedge i_clk) begin
    if (accept && !i_rst && i_req_we && !req_err) begin
      for (int b = 0; b < NB; b++) begin
        if (req_be[b]) mem[req_idx][8*b +: 8] <= req_wsh[8*b +: 8];
      end
    end
  end

  // Load path from the latched request: shift the word down, keep the access size, then extend
  always_comb begin
    lat_idx  = lat_addr[ADDR_BIT-1:OFS];
    lat_off  = lat_addr[OFS-1:0];
    lat_size = lat_funct3[1:0];
    rd_shift = mem[lat_idx] >> {lat_off, 3'b000};
    nbits    = 8 << lat_size;
    case (lat_size)
      2'd0:    ext_bit = rd_shift[7];
      2'd1:    ext_bit = rd_shift[15];
      2'd2:    ext_bit = rd_shift[31];
      default: ext_bit = rd_shift[XLEN-1];
    endcase
    if (lat_funct3[2]) ext_bit = 1'b0;
    for (int i = 0; i < XLEN; i++) begin
      load_data[i] = (i < nbits) ? rd_shift[i] : ext_bit;
    end
    if (lat_we || lat_err) load_data = '0;
  end

  // Request/response FSM. WAIT lasts RD_LAT+1 cycles: RD_LAT wait states followed by the
  // cycle whose closing edge samples the array into the registered response.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      o_req_ready <= 1'b1;
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= '0;
      o_rsp_err   <= 1'b0;
      lat_we      <= 1'b0;
      lat_funct3  <= '0;
      lat_addr    <= '0;
      lat_err     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_req_valid) begin
            lat_we      <= i_req_we;
            lat_funct3  <= i_req_funct3;
            lat_addr    <= i_req_addr;
            lat_err     <= req_err;
            wait_cnt    <= '0;
            o_req_ready <= 1'b0;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_cnt == LAT) begin
            state       <= S_RESP;
            o_rsp_valid <= 1'b1;
            o_rsp_rdata <= load_data;
            o_rsp_err   <= lat_err;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        S_RESP: begin
          if (i_rsp_ready) begin
            state       <= S_IDLE;
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= '0;
            o_rsp_err   <= 1'b0;
            o_req_ready <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_dmem_ctrl.sv
// tb_riscv_dmem_ctrl: drives a 32-bit/RD_LAT=1 and a 64-bit/RD_LAT=3 controller
// with directed and random load/store traffic. A byte-array reference model
// produces expected responses into per-instance queues; monitors pop and compare
// whenever a response appears, and check latency, stability and handshakes.
module tb_riscv_dmem_ctrl;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic        req_valid [2];
  logic        req_we    [2];
  logic [2:0]  req_f3    [2];
  logic [11:0] req_addr  [2];
  logic [63:0] req_wdata [2];
  logic        rsp_ready [2];

  logic        rdy_a, val_a, err_a, rdy_b, val_b, err_b;
  logic [31:0] rdata_a;
  logic [63:0] rdata_b;

  logic        out_rdy   [2];
  logic        out_val   [2];
  logic        out_err   [2];
  logic [63:0] out_rdata [2];

  logic [7:0]  mdl [2][4096];
  exp_t        q0 [$];
  exp_t        q1 [$];

  always #5 clk = ~clk;

  // Cycle counter used for latency measurement
  always @(posedge clk) cyc <= cyc + 1;

  assign out_rdy[0]   = rdy_a;
  assign out_val[0]   = val_a;
  assign out_err[0]   = err_a;
  assign out_rdata[0] = {32'b0, rdata_a};
  assign out_rdy[1]   = rdy_b;
  assign out_val[1]   = val_b;
  assign out_err[1]   = err_b;
  assign out_rdata[1] = rdata_b;

  riscv_dmem_ctrl #(.XLEN(32), .ADDR_BIT(12), .RD_LAT(1)) dut_a (
    .i_clk(clk), .i_rst(rst_a),
    .i_req_valid(req_valid[0]), .o_req_ready(rdy_a), .i_req_we(req_we[0]),
    .i_req_funct3(req_f3[0]), .i_req_addr(req_addr[0]), .i_req_wdata(req_wdata[0][31:0]),
    .o_rsp_valid(val_a), .i_rsp_ready(rsp_ready[0]), .o_rsp_rdata(rdata_a), .o_rsp_err(err_a)
  );

  riscv_dmem_ctrl #(.XLEN(64), .ADDR_BIT(12), .RD_LAT(3)) dut_b (
    .i_clk(clk), .i_rst(rst_b),
    .i_req_valid(req_valid[1]), .o_req_ready(rdy_b), .i_req_we(req_we[1]),
    .i_req_funct3(req_f3[1]), .i_req_addr(req_addr[1]), .i_req_wdata(req_wdata[1]),
    .o_rsp_valid(val_b), .i_rsp_ready(rsp_ready[1]), .o_rsp_rdata(rdata_b), .o_rsp_err(err_b)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic void pushExp(input int d, input exp_t e);
    if (d == 0) q0.push_back(e); else q1.push_back(e);
  endfunction

  function automatic int qSize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t popExp(input int d);
    return (d == 0) ? q0.pop_front() : q1.pop_front();
  endfunction

  // Reference rules: access of 2**size bytes, little-endian
  function automatic bit isErr(input int xlen, input logic we, input logic [2:0] f3, input int addr);
    int n = 1 << f3[1:0];
    if (xlen == 32 && f3[1:0] == 2'd3) return 1'b1;
    if (f3 == 3'b111) return 1'b1;
    if (xlen == 32 && f3 == 3'b110) return 1'b1;
    if (we && f3[2]) return 1'b1;
    return (addr % n) != 0;
  endfunction

  function automatic void modelStore(input int d, input logic [2:0] f3, input int addr, input logic [63:0] wd);
    int n = 1 << f3[1:0];
    for (int i = 0; i < n; i++) mdl[d][addr + i] = wd[8*i +: 8];
  endfunction

  function automatic logic [63:0] modelLoad(input int d, input int xlen, input logic [2:0] f3, input int addr);
    int n = 1 << f3[1:0];
    logic [63:0] v = 64'h0;
    for (int i = 0; i < n; i++) v = v | (64'(mdl[d][addr + i]) << (8 * i));
    if (!f3[2] && v[8*n - 1]) v = v | ~((64'h1 << (8 * n)) - 64'h1);
    if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    return v;
  endfunction

  // Issue one request: junk is driven while the controller is busy, the real request once ready
  task automatic applyStimulus(input int d, input logic we, input logic [2:0] f3, input int addr,
                               input logic [63:0] wdata, input bit use_exp,
                               input logic [63:0] exp_rdata, input logic exp_err);
    int   xlen = (d == 0) ? 32 : 64;
    bit   got = 1'b0;
    exp_t e;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_rdy[d]) begin
        got = 1'b1;
        break;
      end
      req_valid[d] = 1'b1;
      req_we[d]    = 1'($urandom);
      req_f3[d]    = 3'($urandom);
      req_addr[d]  = 12'($urandom);
      req_wdata[d] = {$urandom, $urandom};
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL dut%0d req_ready timeout: got 0, expected 1", d);
      req_valid[d] = 1'b0;
      return;
    end
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_f3[d]    = f3;
    req_addr[d]  = 12'(addr);
    req_wdata[d] = wdata;
    e.err   = isErr(xlen, we, f3, addr);
    e.rdata = (e.err || we) ? 64'h0 : modelLoad(d, xlen, f3, addr);
    if (use_exp) begin
      e.rdata = exp_rdata;
      e.err   = exp_err;
    end
    e.acc = cyc + 1;
    pushExp(d, e);
    if (we && !isErr(xlen, we, f3, addr)) modelStore(d, f3, addr, wdata);
    @(negedge clk);
    req_valid[d] = 1'b0;
    req_wdata[d] = {$urandom, $urandom};
    req_addr[d]  = 12'($urandom);
  endtask

  // Response monitor: pops expected values, checks latency, stability and ready/valid interplay
  task automatic monitorDut(input int d, input int lat);
    bit          in_rsp = 1'b0;
    bit          just_done = 1'b0;
    int          bp_left = 0;
    int          n_rsp = 0;
    exp_t        cur;
    logic [63:0] snap_d;
    logic        snap_e;
    forever begin
      @(negedge clk);
      if (just_done) begin
        checkOutput($sformatf("dut%0d valid drops after handshake", d), 64'(out_val[d]), 64'h0);
        checkOutput($sformatf("dut%0d ready after handshake", d), 64'(out_rdy[d]), 64'h1);
        just_done = 1'b0;
      end
      if (out_val[d]) begin
        if (!in_rsp) begin
          in_rsp = 1'b1;
          n_rsp++;
          if (qSize(d) == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL dut%0d unexpected response: got rdata %h err %b, expected none",
                     d, out_rdata[d], out_err[d]);
          end else begin
            cur = popExp(d);
            checkOutput($sformatf("dut%0d latency", d), 64'(cyc - cur.acc), 64'(lat + 1));
            checkOutput($sformatf("dut%0d rdata", d), out_rdata[d], cur.rdata);
            checkOutput($sformatf("dut%0d err", d), 64'(out_err[d]), 64'(cur.err));
          end
          snap_d  = out_rdata[d];
          snap_e  = out_err[d];
          bp_left = (n_rsp % 4 == 0) ? 5 : $urandom_range(0, 2);
        end else begin
          checkOutput($sformatf("dut%0d rdata stable", d), out_rdata[d], snap_d);
          checkOutput($sformatf("dut%0d err stable", d), 64'(out_err[d]), 64'(snap_e));
        end
        checkOutput($sformatf("dut%0d req_ready low in response", d), 64'(out_rdy[d]), 64'h0);
        if (bp_left > 0) begin
          rsp_ready[d] = 1'b0;
          bp_left--;
        end else begin
          rsp_ready[d] = 1'b1;
          in_rsp    = 1'b0;
          just_done = 1'b1;
        end
      end else begin
        if (in_rsp) begin
          checks++;
          errors++;
          $display("[TB] FAIL dut%0d valid dropped before handshake: got 0, expected 1", d);
          in_rsp = 1'b0;
        end
        rsp_ready[d] = 1'($urandom);
      end
    end
  endtask

  // Reset during WAIT on the 64-bit instance; also a store presented while reset is high
  task automatic resetMidWait();
    bit got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_rdy[1]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL dut1 reset test ready timeout: got 0, expected 1");
      return;
    end
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b1;
    req_f3[1]    = 3'b010;
    req_addr[1]  = 12'h020;
    req_wdata[1] = 64'h0000_0000_A5A5_A5A5;
    modelStore(1, 3'b010, 32'h20, 64'h0000_0000_A5A5_A5A5);
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_b = 1'b1;
    #1;
    checkOutput("dut1 async reset req_ready", 64'(rdy_b), 64'h1);
    checkOutput("dut1 async reset rsp_valid", 64'(val_b), 64'h0);
    checkOutput("dut1 async reset rdata", rdata_b, 64'h0);
    checkOutput("dut1 async reset err", 64'(err_b), 64'h0);
    @(negedge clk);
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b1;
    req_f3[1]    = 3'b010;
    req_addr[1]  = 12'h020;
    req_wdata[1] = 64'h0000_0000_1234_5678;
    @(negedge clk);
    req_valid[1] = 1'b0;
    rst_b        = 1'b0;
    applyStimulus(1, 1'b0, 3'b110, 32'h20, 64'h0, 1'b1, 64'h0000_0000_A5A5_A5A5, 1'b0);
  endtask

  task automatic runA();
    for (int w = 0; w < 16; w++)
      applyStimulus(0, 1'b1, 3'b010, w * 4, {$urandom, $urandom}, 1'b0, 64'h0, 1'b0);
    applyStimulus(0, 1'b1, 3'b010, 32'h10, 64'hDEADBEEF, 1'b1, 64'h0, 1'b0);
    applyStimulus(0, 1'b0, 3'b010, 32'h10, 64'h0, 1'b1, 64'h0000_0000_DEAD_BEEF, 1'b0);
    applyStimulus(0, 1'b0, 3'b000, 32'h13, 64'h0, 1'b1, 64'h0000_0000_FFFF_FFDE, 1'b0);
    applyStimulus(0, 1'b0, 3'b100, 32'h13, 64'h0, 1'b1, 64'h0000_0000_0000_00DE, 1'b0);
    applyStimulus(0, 1'b0, 3'b001, 32'h12, 64'h0, 1'b1, 64'h0000_0000_FFFF_DEAD, 1'b0);
    applyStimulus(0, 1'b0, 3'b101, 32'h10, 64'h0, 1'b1, 64'h0000_0000_0000_BEEF, 1'b0);
    applyStimulus(0, 1'b1, 3'b000, 32'h11, 64'h55, 1'b1, 64'h0, 1'b0);
    applyStimulus(0, 1'b0, 3'b010, 32'h10, 64'h0, 1'b1, 64'h0000_0000_DEAD_55EF, 1'b0);
    applyStimulus(0, 1'b0, 3'b001, 32'h11, 64'h0, 1'b1, 64'h0, 1'b1);
    applyStimulus(0, 1'b1, 3'b010, 32'h12, 64'h1, 1'b1, 64'h0, 1'b1);
    applyStimulus(0, 1'b0, 3'b010, 32'h10, 64'h0, 1'b1, 64'h0000_0000_DEAD_55EF, 1'b0);
    applyStimulus(0, 1'b0, 3'b011, 32'h10, 64'h0, 1'b1, 64'h0, 1'b1);
    for (int i = 0; i < 120; i++)
      applyStimulus(0, 1'($urandom_range(0, 9) < 3), 3'($urandom), $urandom_range(0, 63),
                    {$urandom, $urandom}, 1'b0, 64'h0, 1'b0);
  endtask

  task automatic runB();
    for (int w = 0; w < 8; w++)
      applyStimulus(1, 1'b1, 3'b011, w * 8, {$urandom, $urandom}, 1'b0, 64'h0, 1'b0);
    applyStimulus(1, 1'b1, 3'b011, 32'h8, 64'h0123_4567_89AB_CDEF, 1'b1, 64'h0, 1'b0);
    applyStimulus(1, 1'b0, 3'b110, 32'hC, 64'h0, 1'b1, 64'h0000_0000_0123_4567, 1'b0);
    applyStimulus(1, 1'b0, 3'b011, 32'h8, 64'h0, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b0);
    applyStimulus(1, 1'b0, 3'b010, 32'hC, 64'h0, 1'b1, 64'h0000_0000_0123_4567, 1'b0);
    applyStimulus(1, 1'b0, 3'b011, 32'hC, 64'h0, 1'b1, 64'h0, 1'b1);
    resetMidWait();
    for (int i = 0; i < 120; i++)
      applyStimulus(1, 1'($urandom_range(0, 9) < 3), 3'($urandom), $urandom_range(0, 63),
                    {$urandom, $urandom}, 1'b0, 64'h0, 1'b0);
  endtask

  // Main sequence: reset, start monitors, run both instances, drain the scoreboards
  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0;
      req_we[d]    = 1'b0;
      req_f3[d]    = 3'b0;
      req_addr[d]  = 12'h0;
      req_wdata[d] = 64'h0;
      rsp_ready[d] = 1'b0;
    end
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 4096; a++) mdl[d][a] = 8'h0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("dut%0d reset req_ready", d), 64'(out_rdy[d]), 64'h1);
      checkOutput($sformatf("dut%0d reset rsp_valid", d), 64'(out_val[d]), 64'h0);
      checkOutput($sformatf("dut%0d reset rdata", d), out_rdata[d], 64'h0);
      checkOutput($sformatf("dut%0d reset err", d), 64'(out_err[d]), 64'h0);
    end
    rst_a = 1'b0;
    rst_b = 1'b0;
    fork
      monitorDut(0, 1);
      monitorDut(1, 3);
    join_none
    fork
      runA();
      runB();
    join
    for (int i = 0; i < 300 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
    checkOutput("pending responses at end", 64'(q0.size() + q1.size()), 64'h0);
    repeat (3) @(negedge clk);
    $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
